// File: rtl/subtractor_16bits_pipeline.sv
// 16-bit subtractor y = a - b - bi evaluated as two 8-bit slices on successive cycles,
// with valid/ready handshakes on operands and on the flagged result.
module subtractor_16bits_pipeline #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              bo,
    output logic              zero,
    output logic              overflow
);

    localparam int unsigned SW = DATA_W / 2;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t state, state_next;

    logic [SW-1:0] a_lo, b_lo, a_hi, b_hi;
    logic [SW-1:0] y_lo, y_hi;
    logic          bi_r, borrow_lo, bo_r, zero_r, ovf_r;
    logic [SW:0]   lo_diff, hi_diff;

    // 9-bit slice differences; bit SW is the borrow into the next slice
    always_comb begin
        lo_diff = {1'b0, a_lo} - {1'b0, b_lo} - {{SW{1'b0}}, bi_r};
        hi_diff = {1'b0, a_hi} - {1'b0, b_hi} - {{SW{1'b0}}, borrow_lo};
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LO;
            end
            LO:   state_next = HI;
            HI:   state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_lo      <= '0;
            b_lo      <= '0;
            a_hi      <= '0;
            b_hi      <= '0;
            bi_r      <= 1'b0;
            y_lo      <= '0;
            y_hi      <= '0;
            borrow_lo <= 1'b0;
            bo_r      <= 1'b0;
            zero_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_lo <= a[SW-1:0];
                        b_lo <= b[SW-1:0];
                        a_hi <= a[DATA_W-1:SW];
                        b_hi <= b[DATA_W-1:SW];
                        bi_r <= bi;
                    end
                end
                LO: {borrow_lo, y_lo} <= lo_diff;
                HI: begin
                    {bo_r, y_hi} <= hi_diff;
                    // flags settle together with the high slice so they hold with the result
                    zero_r <= ({hi_diff[SW-1:0], y_lo} == '0);
                    ovf_r  <= (a_hi[SW-1] ^ b_hi[SW-1]) & (hi_diff[SW-1] ^ a_hi[SW-1]);
                end
                default: ;
            endcase
        end
    end

    assign y        = {y_hi, y_lo};
    assign bo       = bo_r;
    assign zero     = zero_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_subtractor_16bits_pipeline.sv
// Scoreboard bench for subtractor_16bits_pipeline: expectations queued at accept, checked at result.
module tb_subtractor_16bits_pipeline;

    typedef struct packed {
        logic [15:0] y;
        logic        bo;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bi = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] y;
    logic        bo, zero, overflow;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    subtractor_16bits_pipeline #(.DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bi(bi),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .bo(bo), .zero(zero), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbi);
        logic [16:0] d;
        exp_t e;
        d      = {1'b0, ma} - {1'b0, mb} - {16'h0, mbi};
        e.y    = d[15:0];
        e.bo   = d[16];
        e.zero = (d[15:0] == 16'h0);
        e.ovf  = (ma[15] ^ mb[15]) & (d[15] ^ ma[15]);
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    task automatic run(input logic [15:0] ta, input logic [15:0] tb, input logic tbi, input int hold);
        int   lat = 0;
        exp_t e;
        wait_ready();
        in_valid = 1'b1; a = ta; b = tb; bi = tbi;
        @(posedge clk);
        q.push_back(model(ta, tb, tbi));
        #1;
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); bi = 1'($urandom);
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency", lat, 3);
        check("in_ready_in_done", in_ready, 0);
        check("sb_size", q.size(), 1);
        e = (q.size() > 0) ? q.pop_front() : '0;
        check("y", y, e.y);
        check("bo", bo, e.bo);
        check("zero", zero, e.zero);
        check("overflow", overflow, e.ovf);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready, 0);
            check("bp_hold", {y, bo, zero, overflow}, {e.y, e.bo, e.zero, e.ovf});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_valid", out_valid, 0);
        check("post_hs_ready", in_ready, 1);
    endtask

    task automatic run_abort(input logic [15:0] ta, input logic [15:0] tb);
        logic seen = 1'b0;
        wait_ready();
        in_valid = 1'b1; a = ta; b = tb; bi = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_out", {out_valid, y, bo, zero, overflow}, 0);
        check("abort_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("abort_no_valid", seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out", {out_valid, y, bo, zero, overflow}, 0);
        check("rst_ready", in_ready, 1);

        run(16'h1234, 16'h0234, 1'b0, 0);
        run(16'h0000, 16'h0001, 1'b0, 0);
        run(16'h0100, 16'h0000, 1'b1, 0);
        run(16'h8000, 16'h0001, 1'b0, 0);
        run(16'h5A5A, 16'h5A5A, 1'b0, 0);
        run(16'h0000, 16'hFFFF, 1'b1, 0);
        run(16'h7FFF, 16'hFFFF, 1'b0, 5);
        run(16'hABCD, 16'h1234, 1'b1, 0);
        run_abort(16'hFFFF, 16'h0001);
        run(16'h0003, 16'h0001, 1'b0, 0);
        for (int i = 0; i < 20; i++)
            run(16'($urandom), 16'($urandom), 1'($urandom), (i % 7 == 3) ? 2 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
